// File: rtl/otter_mem_arbiter.sv
// otter_mem_arbiter
// Shares the single Otter memory port between instruction fetch (IF) and
// data access (D). One requester is granted at a time. The memory request is
// held until M_ACK. Read data comes back with a one-cycle VALID pulse, and
// STALL tells the hazard unit to freeze the pipeline.
// Optional feature: define OTTER_ARB_TIMEOUT_EN to add a BUSY-state watchdog
// that aborts with 32'hDEADBEEF and a one-cycle ERR pulse.

module otter_mem_arbiter #(
    parameter int unsigned STARVE_LIMIT   = 4,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        IF_REQ,
    input  logic [31:0] IF_ADDR,
    output logic [31:0] IF_DATA,
    output logic        IF_VALID,
    input  logic        D_REQ,
    input  logic        D_WE,
    input  logic [31:0] D_ADDR,
    input  logic [31:0] D_WDATA,
    input  logic [1:0]  D_SIZE,
    input  logic        D_SIGN,
    output logic [31:0] D_RDATA,
    output logic        D_VALID,
    output logic        M_REQ,
    output logic        M_WE,
    output logic [31:0] M_ADDR,
    output logic [31:0] M_WDATA,
    output logic [1:0]  M_SIZE,
    output logic        M_SIGN,
    input  logic [31:0] M_RDATA,
    input  logic        M_ACK,
    output logic        STALL,
    output logic        ERR
);

    typedef enum logic [1:0] {IDLE, BUSY_IF, BUSY_D, RESP} state_t;

    localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);

    state_t      state_q;
    logic [3:0]  starve_q;
    logic [31:0] if_data_q;
    logic        if_valid_q;
    logic [31:0] d_rdata_q;
    logic        d_valid_q;
    logic        m_req_q;
    logic        m_we_q;
    logic [31:0] m_addr_q;
    logic [31:0] m_wdata_q;
    logic [1:0]  m_size_q;
    logic        m_sign_q;
    logic        grant_if_d;
    logic        grant_d_d;

`ifdef OTTER_ARB_TIMEOUT_EN
    localparam logic [15:0] WD_LAST = 16'(TIMEOUT_CYCLES - 1);
    logic [15:0] wd_q;
    logic        err_q;
`else
    // The watchdog length has no effect when the watchdog is not built.
    localparam int unsigned TIMEOUT_UNUSED = TIMEOUT_CYCLES;
`endif

    // Arbitration: D wins ties unless IF has been passed over STARVE_LIMIT times.
    always_comb begin
        grant_if_d = IF_REQ & (~D_REQ | (starve_q == STARVE_MAX));
        grant_d_d  = D_REQ & ~grant_if_d;
    end

    // Request FSM: grant in IDLE, hold the memory request until ACK, pulse VALID in RESP.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q    <= IDLE;
            starve_q   <= '0;
            if_data_q  <= '0;
            if_valid_q <= 1'b0;
            d_rdata_q  <= '0;
            d_valid_q  <= 1'b0;
            m_req_q    <= 1'b0;
            m_we_q     <= 1'b0;
            m_addr_q   <= '0;
            m_wdata_q  <= '0;
            m_size_q   <= '0;
            m_sign_q   <= 1'b0;
`ifdef OTTER_ARB_TIMEOUT_EN
            wd_q       <= '0;
            err_q      <= 1'b0;
`endif
        end else begin
            if_valid_q <= 1'b0;
            d_valid_q  <= 1'b0;
`ifdef OTTER_ARB_TIMEOUT_EN
            err_q      <= 1'b0;
`endif
            case (state_q)
                IDLE: begin
                    if (grant_if_d) begin
                        m_req_q   <= 1'b1;
                        m_we_q    <= 1'b0;
                        m_addr_q  <= IF_ADDR;
                        m_wdata_q <= '0;
                        m_size_q  <= 2'b10;
                        m_sign_q  <= 1'b0;
                        starve_q  <= '0;
                        state_q   <= BUSY_IF;
`ifdef OTTER_ARB_TIMEOUT_EN
                        wd_q      <= '0;
`endif
                    end else if (grant_d_d) begin
                        m_req_q   <= 1'b1;
                        m_we_q    <= D_WE;
                        m_addr_q  <= D_ADDR;
                        m_wdata_q <= D_WDATA;
                        m_size_q  <= D_SIZE;
                        m_sign_q  <= D_SIGN;
                        if (IF_REQ && (starve_q != STARVE_MAX)) begin
                            starve_q <= starve_q + 4'd1;
                        end
                        state_q   <= BUSY_D;
`ifdef OTTER_ARB_TIMEOUT_EN
                        wd_q      <= '0;
`endif
                    end
                end
                BUSY_IF, BUSY_D: begin
                    if (M_ACK) begin
                        m_req_q <= 1'b0;
                        state_q <= RESP;
                        if (state_q == BUSY_IF) begin
                            if_data_q  <= M_RDATA;
                            if_valid_q <= 1'b1;
                        end else begin
                            // Stores complete without touching the load data register.
                            if (!m_we_q) begin
                                d_rdata_q <= M_RDATA;
                            end
                            d_valid_q <= 1'b1;
                        end
`ifdef OTTER_ARB_TIMEOUT_EN
                    end else if (wd_q == WD_LAST) begin
                        m_req_q <= 1'b0;
                        err_q   <= 1'b1;
                        state_q <= RESP;
                        if (state_q == BUSY_IF) begin
                            if_data_q  <= 32'hDEAD_BEEF;
                            if_valid_q <= 1'b1;
                        end else begin
                            d_rdata_q <= 32'hDEAD_BEEF;
                            d_valid_q <= 1'b1;
                        end
                    end else begin
                        wd_q <= wd_q + 16'd1;
`endif
                    end
                end
                RESP: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign IF_DATA  = if_data_q;
    assign IF_VALID = if_valid_q;
    assign D_RDATA  = d_rdata_q;
    assign D_VALID  = d_valid_q;
    assign M_REQ    = m_req_q;
    assign M_WE     = m_we_q;
    assign M_ADDR   = m_addr_q;
    assign M_WDATA  = m_wdata_q;
    assign M_SIZE   = m_size_q;
    assign M_SIGN   = m_sign_q;
    assign STALL    = (IF_REQ & ~if_valid_q) | (D_REQ & ~d_valid_q);
`ifdef OTTER_ARB_TIMEOUT_EN
    assign ERR      = err_q;
`else
    assign ERR      = 1'b0;
`endif

endmodule

// File: tb/tb_otter_mem_arbiter.sv
// Testbench for otter_mem_arbiter: reset, a table of directed single-cycle
// vectors, then hand-written starvation and watchdog/no-watchdog sequences.

module tb_otter_mem_arbiter;

    localparam logic O = 1'b0;
    localparam logic I = 1'b1;

    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic        IF_REQ = 1'b0;
    logic [31:0] IF_ADDR = '0;
    logic [31:0] IF_DATA;
    logic        IF_VALID;
    logic        D_REQ = 1'b0;
    logic        D_WE = 1'b0;
    logic [31:0] D_ADDR = '0;
    logic [31:0] D_WDATA = '0;
    logic [1:0]  D_SIZE = '0;
    logic        D_SIGN = 1'b0;
    logic [31:0] D_RDATA;
    logic        D_VALID;
    logic        M_REQ;
    logic        M_WE;
    logic [31:0] M_ADDR;
    logic [31:0] M_WDATA;
    logic [1:0]  M_SIZE;
    logic        M_SIGN;
    logic [31:0] M_RDATA = '0;
    logic        M_ACK = 1'b0;
    logic        STALL;
    logic        ERR;

    int n_cmp = 0;
    int n_bad = 0;

    otter_mem_arbiter #(
        .STARVE_LIMIT  (4),
        .TIMEOUT_CYCLES(8)
    ) dut (
        .CLK     (CLK),
        .RST     (RST),
        .IF_REQ  (IF_REQ),
        .IF_ADDR (IF_ADDR),
        .IF_DATA (IF_DATA),
        .IF_VALID(IF_VALID),
        .D_REQ   (D_REQ),
        .D_WE    (D_WE),
        .D_ADDR  (D_ADDR),
        .D_WDATA (D_WDATA),
        .D_SIZE  (D_SIZE),
        .D_SIGN  (D_SIGN),
        .D_RDATA (D_RDATA),
        .D_VALID (D_VALID),
        .M_REQ   (M_REQ),
        .M_WE    (M_WE),
        .M_ADDR  (M_ADDR),
        .M_WDATA (M_WDATA),
        .M_SIZE  (M_SIZE),
        .M_SIGN  (M_SIGN),
        .M_RDATA (M_RDATA),
        .M_ACK   (M_ACK),
        .STALL   (STALL),
        .ERR     (ERR)
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic        if_req;
        logic [31:0] if_addr;
        logic        d_req;
        logic        d_we;
        logic [31:0] d_addr;
        logic [31:0] d_wdata;
        logic [1:0]  d_size;
        logic        d_sign;
        logic        m_ack;
        logic [31:0] m_rdata;
        logic        e_mreq;
        logic        e_mwe;
        logic [31:0] e_maddr;
        logic [31:0] e_mwdata;
        logic [1:0]  e_msize;
        logic        e_msign;
        logic        e_ifv;
        logic [31:0] e_ifdata;
        logic        e_dv;
        logic [31:0] e_drdata;
        logic        e_stall;
    } vec_t;

    vec_t tbl [23];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic wait_mreq(input string name);
        int waited;
        waited = 0;
        while (M_REQ !== 1'b1 && waited < 20) begin
            step();
            waited++;
        end
        chk(name, {31'b0, M_REQ}, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, got running, expected done");
        $fatal(1, "global timeout");
    end

    initial begin
        //              ifr ifaddr        dr dwe daddr          dwdata        dsz    dsg ack rdata           | mreq mwe maddr         mwdata        msz   msg ifv ifdata       dv drdata         stall
        tbl[0]  = '{O, 32'h0,  O, O, 32'h0,    32'h0,  2'd0, O, O, 32'h0,        O, O, 32'h0,    32'h0,  2'd0, O, O, 32'h0,  O, 32'h0,        O};
        tbl[1]  = '{I, 32'h40, O, O, 32'h0,    32'h0,  2'd0, O, O, 32'h0,        I, O, 32'h40,   32'h0,  2'd2, O, O, 32'h0,  O, 32'h0,        I};
        tbl[2]  = '{I, 32'h40, O, O, 32'h0,    32'h0,  2'd0, O, I, 32'h13,       O, O, 32'h40,   32'h0,  2'd2, O, I, 32'h13, O, 32'h0,        O};
        tbl[3]  = '{O, 32'h40, O, O, 32'h0,    32'h0,  2'd0, O, O, 32'h0,        O, O, 32'h40,   32'h0,  2'd2, O, O, 32'h13, O, 32'h0,        O};
        tbl[4]  = '{I, 32'h44, I, O, 32'h1000, 32'h0,  2'd2, O, O, 32'h0,        I, O, 32'h1000, 32'h0,  2'd2, O, O, 32'h13, O, 32'h0,        I};
        tbl[5]  = '{I, 32'h44, I, O, 32'h1000, 32'h0,  2'd2, O, O, 32'h0,        I, O, 32'h1000, 32'h0,  2'd2, O, O, 32'h13, O, 32'h0,        I};
        tbl[6]  = '{I, 32'h44, I, O, 32'h1000, 32'h0,  2'd2, O, I, 32'hCAFE0001, O, O, 32'h1000, 32'h0,  2'd2, O, O, 32'h13, I, 32'hCAFE0001, I};
        tbl[7]  = '{I, 32'h44, O, O, 32'h1000, 32'h0,  2'd2, O, O, 32'h0,        O, O, 32'h1000, 32'h0,  2'd2, O, O, 32'h13, O, 32'hCAFE0001, I};
        tbl[8]  = '{I, 32'h44, O, O, 32'h1000, 32'h0,  2'd2, O, O, 32'h0,        I, O, 32'h44,   32'h0,  2'd2, O, O, 32'h13, O, 32'hCAFE0001, I};
        tbl[9]  = '{I, 32'h44, O, O, 32'h1000, 32'h0,  2'd2, O, I, 32'h93,       O, O, 32'h44,   32'h0,  2'd2, O, I, 32'h93, O, 32'hCAFE0001, O};
        tbl[10] = '{O, 32'h44, O, O, 32'h1000, 32'h0,  2'd2, O, O, 32'h0,        O, O, 32'h44,   32'h0,  2'd2, O, O, 32'h93, O, 32'hCAFE0001, O};
        tbl[11] = '{I, 32'h80, O, O, 32'h0,    32'h0,  2'd0, O, O, 32'h0,        I, O, 32'h80,   32'h0,  2'd2, O, O, 32'h93, O, 32'hCAFE0001, I};
        tbl[12] = '{O, 32'h80, O, O, 32'h0,    32'h0,  2'd0, O, O, 32'h0,        I, O, 32'h80,   32'h0,  2'd2, O, O, 32'h93, O, 32'hCAFE0001, O};
        tbl[13] = '{O, 32'h80, O, O, 32'h0,    32'h0,  2'd0, O, I, 32'h11,       O, O, 32'h80,   32'h0,  2'd2, O, I, 32'h11, O, 32'hCAFE0001, O};
        tbl[14] = '{O, 32'h80, O, O, 32'h0,    32'h0,  2'd0, O, O, 32'h0,        O, O, 32'h80,   32'h0,  2'd2, O, O, 32'h11, O, 32'hCAFE0001, O};
        tbl[15] = '{O, 32'h0,  I, I, 32'h2000, 32'hAB, 2'd0, O, O, 32'h0,        I, I, 32'h2000, 32'hAB, 2'd0, O, O, 32'h11, O, 32'hCAFE0001, I};
        tbl[16] = '{O, 32'h0,  I, I, 32'h2000, 32'hAB, 2'd0, O, O, 32'h55555555, I, I, 32'h2000, 32'hAB, 2'd0, O, O, 32'h11, O, 32'hCAFE0001, I};
        tbl[17] = '{O, 32'h0,  I, I, 32'h2000, 32'hAB, 2'd0, O, I, 32'h77777777, O, I, 32'h2000, 32'hAB, 2'd0, O, O, 32'h11, I, 32'hCAFE0001, O};
        tbl[18] = '{O, 32'h0,  O, I, 32'h2000, 32'hAB, 2'd0, O, O, 32'h0,        O, I, 32'h2000, 32'hAB, 2'd0, O, O, 32'h11, O, 32'hCAFE0001, O};
        tbl[19] = '{O, 32'h0,  O, O, 32'h0,    32'h0,  2'd0, O, I, 32'h12345678, O, I, 32'h2000, 32'hAB, 2'd0, O, O, 32'h11, O, 32'hCAFE0001, O};
        tbl[20] = '{O, 32'h0,  I, O, 32'h3002, 32'h0,  2'd1, I, O, 32'h0,        I, O, 32'h3002, 32'h0,  2'd1, I, O, 32'h11, O, 32'hCAFE0001, I};
        tbl[21] = '{O, 32'h0,  I, O, 32'h3002, 32'h0,  2'd1, I, I, 32'h0000BEEF, O, O, 32'h3002, 32'h0,  2'd1, I, O, 32'h11, I, 32'h0000BEEF, O};
        tbl[22] = '{O, 32'h0,  O, O, 32'h3002, 32'h0,  2'd1, I, O, 32'h0,        O, O, 32'h3002, 32'h0,  2'd1, I, O, 32'h11, O, 32'h0000BEEF, O};

        // Reset held with a pending fetch: every registered output stays 0.
        IF_REQ  = 1'b1;
        IF_ADDR = 32'h200;
        step();
        step();
        chk("rst_mreq",   {31'b0, M_REQ},    32'd0);
        chk("rst_maddr",  M_ADDR,            32'd0);
        chk("rst_ifv",    {31'b0, IF_VALID}, 32'd0);
        chk("rst_dv",     {31'b0, D_VALID},  32'd0);
        chk("rst_ifdata", IF_DATA,           32'd0);
        chk("rst_drdata", D_RDATA,           32'd0);
        chk("rst_err",    {31'b0, ERR},      32'd0);
        RST = 1'b1;
        step();
        chk("rel_mreq",  {31'b0, M_REQ}, 32'd1);
        chk("rel_maddr", M_ADDR,         32'h200);

        // Asynchronous reset mid-transaction drops it without a VALID.
        #2;
        RST = 1'b0;
        #1;
        chk("arst_mreq",  {31'b0, M_REQ}, 32'd0);
        chk("arst_maddr", M_ADDR,         32'd0);
        IF_REQ = 1'b0;
        M_ACK  = 1'b1;
        step();
        RST = 1'b1;
        step();
        chk("arst_noifv", {31'b0, IF_VALID}, 32'd0);
        chk("arst_idle",  {31'b0, M_REQ},    32'd0);
        M_ACK = 1'b0;
        step();

        // Directed vector table.
        for (int i = 0; i < 23; i++) begin
            IF_REQ  = tbl[i].if_req;
            IF_ADDR = tbl[i].if_addr;
            D_REQ   = tbl[i].d_req;
            D_WE    = tbl[i].d_we;
            D_ADDR  = tbl[i].d_addr;
            D_WDATA = tbl[i].d_wdata;
            D_SIZE  = tbl[i].d_size;
            D_SIGN  = tbl[i].d_sign;
            M_ACK   = tbl[i].m_ack;
            M_RDATA = tbl[i].m_rdata;
            step();
            chk($sformatf("v%0d_mreq", i),   {31'b0, M_REQ},    {31'b0, tbl[i].e_mreq});
            chk($sformatf("v%0d_mwe", i),    {31'b0, M_WE},     {31'b0, tbl[i].e_mwe});
            chk($sformatf("v%0d_maddr", i),  M_ADDR,            tbl[i].e_maddr);
            chk($sformatf("v%0d_mwdata", i), M_WDATA,           tbl[i].e_mwdata);
            chk($sformatf("v%0d_msize", i),  {30'b0, M_SIZE},   {30'b0, tbl[i].e_msize});
            chk($sformatf("v%0d_msign", i),  {31'b0, M_SIGN},   {31'b0, tbl[i].e_msign});
            chk($sformatf("v%0d_ifv", i),    {31'b0, IF_VALID}, {31'b0, tbl[i].e_ifv});
            chk($sformatf("v%0d_ifdata", i), IF_DATA,           tbl[i].e_ifdata);
            chk($sformatf("v%0d_dv", i),     {31'b0, D_VALID},  {31'b0, tbl[i].e_dv});
            chk($sformatf("v%0d_drdata", i), D_RDATA,           tbl[i].e_drdata);
            chk($sformatf("v%0d_stall", i),  {31'b0, STALL},    {31'b0, tbl[i].e_stall});
            chk($sformatf("v%0d_err", i),    {31'b0, ERR},      32'd0);
        end
        M_ACK = 1'b0;

        // Starvation: IF held, D re-requesting continuously.
        begin
            int cnt;
            logic exp_if;
            cnt     = 0;
            IF_REQ  = 1'b1;
            IF_ADDR = 32'h100;
            D_REQ   = 1'b1;
            D_WE    = 1'b0;
            D_ADDR  = 32'h4000;
            D_WDATA = 32'h0;
            D_SIZE  = 2'd2;
            D_SIGN  = 1'b0;
            for (int g = 0; g < 6; g++) begin
                if (cnt == 4) begin
                    exp_if = 1'b1;
                    cnt    = 0;
                end else begin
                    exp_if = 1'b0;
                    cnt    = cnt + 1;
                end
                wait_mreq($sformatf("starve_wait%0d", g));
                chk($sformatf("starve_grant%0d", g), M_ADDR, exp_if ? 32'h100 : 32'h4000);
                M_ACK   = 1'b1;
                M_RDATA = 32'h900 + 32'(g);
                step();
                M_ACK = 1'b0;
                if (exp_if) begin
                    chk($sformatf("starve_ifv%0d", g), {31'b0, IF_VALID}, 32'd1);
                end else begin
                    chk($sformatf("starve_dv%0d", g), {31'b0, D_VALID}, 32'd1);
                end
                if (g == 5) begin
                    IF_REQ = 1'b0;
                    D_REQ  = 1'b0;
                end
                step();
            end
        end

        // Memory never acknowledges a D load.
        D_REQ  = 1'b1;
        D_WE   = 1'b0;
        D_ADDR = 32'h5000;
        wait_mreq("to_wait");
`ifdef OTTER_ARB_TIMEOUT_EN
        for (int k = 1; k < 8; k++) begin
            step();
            chk($sformatf("to_busy%0d", k), {31'b0, M_REQ},   32'd1);
            chk($sformatf("to_nodv%0d", k), {31'b0, D_VALID}, 32'd0);
        end
        step();
        chk("to_dv",     {31'b0, D_VALID}, 32'd1);
        chk("to_err",    {31'b0, ERR},     32'd1);
        chk("to_drdata", D_RDATA,          32'hDEADBEEF);
        chk("to_mreq",   {31'b0, M_REQ},   32'd0);
        D_REQ = 1'b0;
        step();
        chk("to_err_pulse", {31'b0, ERR},     32'd0);
        chk("to_dv_pulse",  {31'b0, D_VALID}, 32'd0);
        step();
        chk("to_idle", {31'b0, M_REQ}, 32'd0);
`else
        for (int k = 1; k <= 20; k++) begin
            step();
            chk($sformatf("nw_busy%0d", k), {31'b0, M_REQ}, 32'd1);
            chk($sformatf("nw_err%0d", k),  {31'b0, ERR},   32'd0);
        end
        chk("nw_nodv", {31'b0, D_VALID}, 32'd0);
        M_ACK   = 1'b1;
        M_RDATA = 32'h600D;
        step();
        M_ACK = 1'b0;
        D_REQ = 1'b0;
        chk("nw_dv",     {31'b0, D_VALID}, 32'd1);
        chk("nw_drdata", D_RDATA,          32'h600D);
        chk("nw_err",    {31'b0, ERR},     32'd0);
        step();
        step();
        chk("nw_idle", {31'b0, M_REQ}, 32'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
